foc_mul_share_arb: RTL and testbench
====================================

Name: foc_mul_share_arb

Overview:
- Time-shares one pipelined 15-bit unsigned x 15-bit signed multiplier (foc_mul_mul_15ns_15s_30_4_1) between NREQ FOC datapath requesters, for example the Park, Clarke and PI stages.
- Round-robin arbitration; at most one operand pair is issued per cycle.
- Each result returns on one shared result port, tagged with the requester index and a user tag.
- Backpressure on the result port stalls the whole multiplier pipeline through its ce input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index, equal to clog2(NREQ).
- TAGW, 4, width of the user tag carried with each operation.
- LAT, 3, clock edges from operand acceptance to product at dout. This is fixed by the multiplier and is a localparam in the package, not a user parameter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*15  unsigned operand a; slice i belongs to requester i.
- req_b  in  NREQ*15  signed operand b; slice i belongs to requester i.
- req_tag  in  NREQ*TAGW  user tag; slice i belongs to requester i.
- res_valid  out  1  product valid.
- res_ready  in  1  result consumer ready.
- res_p  out  30  signed product, $signed({1'b0,a})*b.
- res_id  out  IDW  index of the requester that issued the operation.
- res_tag  out  TAGW  tag issued with the operation.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset values (asynchronous, while reset_n is low):
  - valid pipeline, id pipeline, tag pipeline and round-robin pointer are cleared to 0.
  - res_valid=0, res_id=0, res_tag=0, busy=0, req_ready=0.
  - res_p is undefined until the first valid result; the multiplier has no reset.
- Stall:
  - ce = ~(res_valid & ~res_ready).
  - ce drives the multiplier and all sideband pipeline registers.
  - When ce=0 every stage holds its value and req_ready is all zeros.
- Arbitration (combinational):
  - Starting at index ptr, the first i in ascending modulo-NREQ order with req_valid[i]=1 wins.
  - req_ready[winner] = ce. No other bit of req_ready is set.
  - The transfer happens on an edge where req_valid[i] & req_ready[i].
  - On a transfer, ptr <= winner+1 (mod NREQ). Otherwise ptr holds.
- Issue:
  - A mux selects the winner's a and b onto the multiplier din0/din1.
  - When there is no winner, the mux drives zeros and a bubble (valid=0) enters the pipeline.
- Sideband pipeline:
  - LAT-deep shift registers hold {valid, id, tag} and advance only when ce=1.
  - An operand accepted at edge E has res_p, res_valid, res_id and res_tag presented from edge E+LAT, provided no stall occurred.
  - Each stall cycle adds one cycle to that latency.
- Output:
  - res_valid is the last stage of the valid pipeline.
  - A result is consumed on an edge with res_valid & res_ready.
- Throughput:
  - One operation per cycle with res_ready held high.
  - A bubble does not stall: ce stays 1 while res_valid=0.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
  - Requester i waits at most NREQ-1 grants.
- Other rules:
  - busy is the OR of all valid-pipeline stages.
  - req_valid may drop without a transfer; no error and no pointer change.
- Reset mid-operation:
  - All in-flight operations are discarded: valid stages cleared, no result is emitted.
  - After reset_n rises, the first result can appear only for operands accepted after reset.

Decomposition:
- Package foc_mul_share_pkg holds:
  - localparams MUL_AW=15, MUL_BW=15, MUL_PW=30, LAT=3;
  - a typedef for the sideband struct {valid, id, tag}.
- Sub-module foc_rr_arb (NREQ): combinational round-robin grant plus registered pointer, with a grant enable input (ce).
- foc_mul_mul_15ns_15s_30_4_1 is instantiated as-is, with reset tied to ~reset_n. It is unused internally.

Test Plan:
- Single op, requester 2: a=100, b=-3, tag=5, res_ready=1.
  -> res_valid at edge +3, res_p=-300, res_id=2, res_tag=5, busy low after consumption.
- Extremes: a=32767, b=-16384.
  -> res_p=-536854528. With a=32767, b=16383 -> res_p=536821761.
- All 4 valid for 8 cycles, distinct tags.
  -> grants 0,1,2,3,0,1,2,3 back-to-back; results in the same order, one per cycle.
- res_ready low for 5 cycles while 3 ops are in flight.
  -> ce=0, req_ready=0, res_* stable; on release the 3 results drain in order with none lost or duplicated.
- Only requesters 1 and 3 valid, ptr=2.
  -> grant 3 first, then 1, then 3.
- reset_n low for 1 cycle with 2 ops in flight.
  -> res_valid stays 0, ptr=0; the next op accepted after reset returns correctly with latency 3.

Source files
------------

// File: rtl/foc_mul_share_arb_pkg.sv
// Shared constants and sideband record for the time-shared FOC multiplier.
// The multiplier geometry and latency are fixed by the multiplier itself.
package foc_mul_share_pkg;

    localparam int MUL_AW = 15;
    localparam int MUL_BW = 15;
    localparam int MUL_PW = 30;
    localparam int LAT    = 3;

    // Sideband fields are sized for the largest supported configuration
    // (NREQ up to 8, TAGW up to 16); unused upper bits stay zero.
    localparam int SB_IDW  = 3;
    localparam int SB_TAGW = 16;

    typedef struct packed {
        logic               valid;
        logic [SB_IDW-1:0]  id;
        logic [SB_TAGW-1:0] tag;
    } sb_t;

endpackage

// File: rtl/foc_mul_mul_15ns_15s_30_4_1.sv
// Pipelined 15-bit unsigned x 15-bit signed multiplier: three register stages
// from din to dout, all advancing on ce. Datapath registers carry no reset.
module foc_mul_mul_15ns_15s_30_4_1 (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [14:0]        din0,
    input  logic [14:0]        din1,
    output logic signed [29:0] dout
);

    logic [14:0]        a_q;
    logic signed [14:0] b_q;
    logic signed [29:0] p1_q;
    logic signed [29:0] p2_q;
    logic signed [29:0] a_ext;
    logic signed [29:0] b_ext;

    // The datapath is intentionally reset-free; the port exists for interface compatibility.
    logic unused_reset;
    assign unused_reset = reset;

    assign a_ext = 30'(signed'({1'b0, a_q}));
    assign b_ext = 30'(b_q);

    always_ff @(posedge clk) begin
        if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            p1_q <= a_ext * b_ext;
            p2_q <= p1_q;
        end
    end

    assign dout = p2_q;

endmodule

// File: rtl/foc_mul_share_arb_rr_arb.sv
// Round-robin arbiter: combinational grant searching upward from ptr,
// registered pointer that moves past the winner only when a grant is taken.
module foc_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            ce,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A grant only counts as taken when ce allows the transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid && ce) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/foc_mul_share_arb.sv
// Time-shares one pipelined multiplier between NREQ requesters. Results come
// back in issue order tagged with requester index and user tag.
module foc_mul_share_arb
    import foc_mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int TAGW = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*MUL_AW-1:0]   req_a,
    input  logic [NREQ*MUL_BW-1:0]   req_b,
    input  logic [NREQ*TAGW-1:0]     req_tag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [MUL_PW-1:0] res_p,
    output logic [IDW-1:0]           res_id,
    output logic [TAGW-1:0]          res_tag,
    output logic                     busy
);

    // Handshake: a requester transfers on an edge with req_valid[i] & req_ready[i];
    // a result is consumed on an edge with res_valid & res_ready. A held result
    // freezes the whole pipeline (ce low) and withdraws every req_ready bit.

    logic              ce;
    logic [NREQ-1:0]   grant;
    logic              grant_valid;
    logic [IDW-1:0]    grant_idx;
    logic [MUL_AW-1:0] din0;
    logic [MUL_BW-1:0] din1;
    sb_t               sb_in;
    sb_t               sb_q [LAT];
    sb_t               sb_d [LAT];

    assign ce = ~(res_valid & ~res_ready);

    foc_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .ce          (ce),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign req_ready = reset_n ? (grant & {NREQ{ce}}) : '0;

    always_comb begin
        din0 = '0;
        din1 = '0;
        if (grant_valid) begin
            din0 = req_a[grant_idx*MUL_AW +: MUL_AW];
            din1 = req_b[grant_idx*MUL_BW +: MUL_BW];
        end
    end

    foc_mul_mul_15ns_15s_30_4_1 u_mul (
        .clk   (clk),
        .reset (~reset_n),
        .ce    (ce),
        .din0  (din0),
        .din1  (din1),
        .dout  (res_p)
    );

    // Sideband shift register tracks the multiplier stage for stage.
    always_comb begin
        sb_in       = '0;
        sb_in.valid = grant_valid;
        sb_in.id    = SB_IDW'(grant_idx);
        sb_in.tag   = SB_TAGW'(req_tag[grant_idx*TAGW +: TAGW]);
        for (int i = 0; i < LAT; i++) begin
            sb_d[i] = sb_q[i];
        end
        if (ce) begin
            sb_d[0] = sb_in;
            for (int i = 1; i < LAT; i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign res_valid = sb_q[LAT-1].valid;
    assign res_id    = sb_q[LAT-1].id[IDW-1:0];
    assign res_tag   = sb_q[LAT-1].tag[TAGW-1:0];

    logic unused_sb_hi;
    assign unused_sb_hi = ^sb_q[LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | sb_q[i].valid;
        end
    end

endmodule

// File: tb/tb_foc_mul_share_arb.sv
// Bench for foc_mul_share_arb: directed scenarios plus random traffic, checked
// against a queue-based model of arbitration, latency and products.
module tb_foc_mul_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TAGW = 4;
  localparam int LAT  = 3;
  localparam int PW   = 30;
  localparam int EW   = IDW + TAGW + PW;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*15-1:0]   req_a;
  logic [NREQ*15-1:0]   req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 res_valid;
  logic                 res_ready;
  logic [PW-1:0]        res_p;
  logic [IDW-1:0]       res_id;
  logic [TAGW-1:0]      res_tag;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results in issue order: {id, tag, product}; age counts
  // stall-free edges since acceptance (acceptance edge counts as 1).
  logic [EW-1:0] exp_q[$];
  int            age_q[$];
  int            ptr_m = 0;
  int            grant_log[$];

  // clock / reset
  always #5 clk = ~clk;

  foc_mul_share_arb #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .TAGW (TAGW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_op(input int i, input int a, input int b, input int t);
    req_a[i*15 +: 15]     = 15'(a);
    req_b[i*15 +: 15]     = 15'(b);
    req_tag[i*TAGW +: TAGW] = TAGW'(t);
  endtask

  task automatic rand_ops();
    for (int r = 0; r < NREQ; r++) begin
      set_op(r, $urandom_range(0, 32767), $urandom, $urandom);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model by what the next rising edge should do.
  task automatic cycle(input logic [NREQ-1:0] v, input logic rr, input logic rn);
    int              win;
    int              a_i;
    int              b_i;
    logic            exp_rv;
    logic            ce_m;
    logic [NREQ-1:0] exp_rdy;
    logic [PW-1:0]   p;
    req_valid = v;
    res_ready = rr;
    reset_n   = rn;
    if (!rn) begin
      exp_q.delete();
      age_q.delete();
      ptr_m = 0;
    end
    #1;
    exp_rv = (age_q.size() > 0) && (age_q[0] >= LAT);
    ce_m   = !(exp_rv && !rr);
    win    = -1;
    if (rn) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && v[(ptr_m + k) % NREQ]) win = (ptr_m + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (win >= 0 && ce_m) exp_rdy[win] = 1'b1;

    check_eq("res_valid", res_valid, exp_rv);
    check_eq("busy", busy, age_q.size() > 0);
    check_eq("req_ready", req_ready, exp_rdy);
    if (exp_rv) begin
      check_eq("res_id", res_id, exp_q[0][EW-1 -: IDW]);
      check_eq("res_tag", res_tag, exp_q[0][PW +: TAGW]);
      check_eq("res_p", res_p, exp_q[0][PW-1:0]);
    end
    if (!rn) begin
      check_eq("rst_res_id", res_id, 0);
      check_eq("rst_res_tag", res_tag, 0);
    end

    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
    end

    if (rn) begin
      if (exp_rv && rr) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      if (ce_m) begin
        foreach (age_q[i]) age_q[i]++;
      end
      if (win >= 0 && ce_m) begin
        a_i = int'(req_a[win*15 +: 15]);
        b_i = int'($signed(req_b[win*15 +: 15]));
        p   = PW'(a_i * b_i);
        exp_q.push_back({IDW'(win), req_tag[win*TAGW +: TAGW], p});
        age_q.push_back(1);
        ptr_m = (win + 1) % NREQ;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b1, 1'b1);
  endtask

  initial begin
    int exp_g[3];
    exp_g = '{3, 1, 3};
    reset_n   = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    #1 reset_n = 1'b0;
    @(negedge clk);

    // reset state, with requests pending
    cycle('1, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);

    // all requesters valid: strict rotation from ptr 0
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      for (int r = 0; r < NREQ; r++) req_tag[r*TAGW +: TAGW] = TAGW'(i);
      cycle('1, 1'b1, 1'b1);
    end
    idle(4);
    check_eq("rot_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check_eq("rot_grant", grant_log[i], i % NREQ);
    end

    // single operation from requester 2
    set_op(2, 100, -3, 5);
    cycle(4'b0100, 1'b1, 1'b1);
    idle(4);

    // operand extremes
    set_op(0, 32767, -16384, 1);
    cycle(4'b0001, 1'b1, 1'b1);
    set_op(0, 32767, 16383, 2);
    cycle(4'b0001, 1'b1, 1'b1);
    idle(4);

    // result backpressure with three operations in flight
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle('1, 1'b1, 1'b1);
    end
    for (int i = 0; i < 5; i++) cycle('1, 1'b0, 1'b1);
    idle(6);

    // sparse requesters 1 and 3 starting from ptr 2
    cycle('0, 1'b1, 1'b0);
    set_op(1, 7, 9, 3);
    cycle(4'b0010, 1'b1, 1'b1);
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle(4'b1010, 1'b1, 1'b1);
    end
    idle(4);
    check_eq("sparse_count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) begin
      check_eq("sparse_grant", grant_log[i], exp_g[i]);
    end

    // reset with two operations in flight
    rand_ops();
    cycle(4'b0001, 1'b1, 1'b1);
    cycle(4'b0001, 1'b1, 1'b1);
    cycle('0, 1'b1, 1'b0);
    idle(4);
    grant_log.delete();
    set_op(0, 1234, -567, 9);
    cycle('1, 1'b1, 1'b1);
    idle(4);
    check_eq("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // random traffic with random backpressure and rare resets
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cycle(NREQ'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
    end

    // bounded drain
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    check_eq("drain_empty", exp_q.size(), 0);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
